mul_16bit_wallace_core: RTL and testbench

MUL_16BIT_WALLACE_CORE -- requirements
Module: mul_16bit_wallace

---
 rtl/mul_16bit_wallace_pkg.sv | 42 ++++
 rtl/mul_wallace_csa.sv | 22 ++
 rtl/mul_16bit_wallace_core.sv | 155 +++++++++++++++
 tb/tb_mul_16bit_wallace_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mul_16bit_wallace_pkg.sv
// -----------------------------------------------------------------------------
// mul_16bit_wallace_pkg
// Shared constants and types for the 16x16 Booth/Wallace multiplier.
//   DATA_WIDTH : operand width
//   RES_WIDTH  : product width
//   PP_NUM     : number of Booth partial products (8 signed, 9 unsigned)
// Configuration macro: MUL_16BIT_WALLACE_UNSIGNED_EN (unsigned operands).
// -----------------------------------------------------------------------------
package mul_16bit_wallace_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int RES_WIDTH  = 32;

`ifdef MUL_16BIT_WALLACE_UNSIGNED_EN
  // The zero-extended 17th multiplier bit needs one extra Booth group.
  localparam int PP_NUM = 9;
`else
  localparam int PP_NUM = 8;
`endif

  // Width of the multiplier with the implicit y[-1]=0 appended below bit 0.
  localparam int Y_EXT_WIDTH = 2 * PP_NUM + 1;

  typedef enum logic [2:0] {
    BS_ZERO,
    BS_PX,
    BS_MX,
    BS_P2X,
    BS_M2X
  } booth_sel_t;

  typedef logic [PP_NUM-1:0][RES_WIDTH-1:0] pp_array_t;

  // One operation walks SAMPLE -> REDUCE -> FINAL -> DONE and parks in DONE.
  typedef enum logic [1:0] {
    ST_SAMPLE,
    ST_REDUCE,
    ST_FINAL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mul_wallace_csa.sv
// -----------------------------------------------------------------------------
// mul_wallace_csa
// Parameterized 3:2 carry-save compressor used at every Wallace tree level.
//   a, b, c : three addend rows
//   sum     : bitwise sum row
//   carry   : majority row, already shifted left by one (weight-aligned)
// -----------------------------------------------------------------------------
module mul_wallace_csa #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  assign sum   = a ^ b ^ c;
  // The carry out of the top bit falls off: all arithmetic is modulo 2^WIDTH.
  assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/mul_16bit_wallace_core.sv
// -----------------------------------------------------------------------------
// mul_16bit_wallace_core
// Three-stage radix-4 Booth / Wallace tree 16x16 multiplier. One operation
// runs after each reset release; results hold until the next reset.
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset (also the start of an operation)
//   i_num_x : multiplicand
//   i_num_y : multiplier
//   o_end   : result valid, sticky until reset
//   o_res   : full 32-bit product (0 while o_end is 0)
//   o_cry   : product does not fit in 16 bits (0 while o_end is 0)
// Configuration macro: MUL_16BIT_WALLACE_UNSIGNED_EN selects unsigned operands.
// -----------------------------------------------------------------------------
module mul_16bit_wallace_core
  import mul_16bit_wallace_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_num_x,
  input  logic [DATA_WIDTH-1:0] i_num_y,
  output logic                  o_end,
  output logic [RES_WIDTH-1:0]  o_res,
  output logic                  o_cry
);

  state_t                 state;
  pp_array_t              pp_d, pp_q;
  logic [RES_WIDTH-1:0]   sum_d, carry_d, sum_q, carry_q;
  logic [RES_WIDTH-1:0]   prod;
  logic                   cry_d;
  logic [RES_WIDTH-1:0]   x_ext;
  logic [Y_EXT_WIDTH-1:0] y_ext;

  // ---------------------------------------------------------------------------
  // Booth recoding: each group {y[2i+1], y[2i], y[2i-1]} picks a multiple of
  // x, which is sign-/zero-extended to the full product width and shifted.
  // ---------------------------------------------------------------------------
`ifdef MUL_16BIT_WALLACE_UNSIGNED_EN
  assign x_ext = {{(RES_WIDTH-DATA_WIDTH){1'b0}}, i_num_x};
`else
  assign x_ext = {{(RES_WIDTH-DATA_WIDTH){i_num_x[DATA_WIDTH-1]}}, i_num_x};
`endif
  assign y_ext = Y_EXT_WIDTH'({i_num_y, 1'b0});

  always_comb begin
    booth_sel_t           sel;
    logic [RES_WIDTH-1:0] mult;
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    pp_d = '0;
    sel  = BS_ZERO;
    mult = '0;
    for (int i = 0; i < PP_NUM; i++) begin
      case (y_ext[2*i +: 3])
        3'b001, 3'b010: sel = BS_PX;
        3'b011:         sel = BS_P2X;
        3'b100:         sel = BS_M2X;
        3'b101, 3'b110: sel = BS_MX;
        default:        sel = BS_ZERO;
      endcase
      case (sel)
        BS_PX:   mult = x_ext;
        BS_MX:   mult = -x_ext;
        BS_P2X:  mult = x_ext << 1;
        BS_M2X:  mult = -(x_ext << 1);
        default: mult = '0;
      endcase
      pp_d[i] = mult << (2 * i);
    end
  end

  // ---------------------------------------------------------------------------
  // Wallace tree: PP_NUM rows -> 6 -> 4 -> 3 -> 2.
  // ---------------------------------------------------------------------------
  logic [5:0][RES_WIDTH-1:0] l1;
  logic [3:0][RES_WIDTH-1:0] l2;
  logic [2:0][RES_WIDTH-1:0] l3;

  mul_wallace_csa #(.WIDTH(RES_WIDTH)) u_csa_l1_0 (
    .a(pp_q[0]), .b(pp_q[1]), .c(pp_q[2]), .sum(l1[0]), .carry(l1[1]));
  mul_wallace_csa #(.WIDTH(RES_WIDTH)) u_csa_l1_1 (
    .a(pp_q[3]), .b(pp_q[4]), .c(pp_q[5]), .sum(l1[2]), .carry(l1[3]));
`ifdef MUL_16BIT_WALLACE_UNSIGNED_EN
  mul_wallace_csa #(.WIDTH(RES_WIDTH)) u_csa_l1_2 (
    .a(pp_q[6]), .b(pp_q[7]), .c(pp_q[8]), .sum(l1[4]), .carry(l1[5]));
`else
  assign l1[4] = pp_q[6];
  assign l1[5] = pp_q[7];
`endif

  mul_wallace_csa #(.WIDTH(RES_WIDTH)) u_csa_l2_0 (
    .a(l1[0]), .b(l1[1]), .c(l1[2]), .sum(l2[0]), .carry(l2[1]));
  mul_wallace_csa #(.WIDTH(RES_WIDTH)) u_csa_l2_1 (
    .a(l1[3]), .b(l1[4]), .c(l1[5]), .sum(l2[2]), .carry(l2[3]));

  mul_wallace_csa #(.WIDTH(RES_WIDTH)) u_csa_l3_0 (
    .a(l2[0]), .b(l2[1]), .c(l2[2]), .sum(l3[0]), .carry(l3[1]));
  assign l3[2] = l2[3];

  mul_wallace_csa #(.WIDTH(RES_WIDTH)) u_csa_l4_0 (
    .a(l3[0]), .b(l3[1]), .c(l3[2]), .sum(sum_d), .carry(carry_d));

  // ---------------------------------------------------------------------------
  // Final carry-propagate adder and 16-bit range check.
  // ---------------------------------------------------------------------------
  assign prod = sum_q + carry_q;

`ifdef MUL_16BIT_WALLACE_UNSIGNED_EN
  assign cry_d = |prod[RES_WIDTH-1:DATA_WIDTH];
`else
  // Representable in 16 signed bits iff bits 31..15 are all copies of one value.
  assign cry_d = ~((&prod[RES_WIDTH-1:DATA_WIDTH-1]) |
                   ~(|prod[RES_WIDTH-1:DATA_WIDTH-1]));
`endif

  // ---------------------------------------------------------------------------
  // Sequencer and pipeline registers. Each stage loads once; DONE freezes
  // everything so inputs are ignored until the next reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the partial-product and row registers are reset too, not just
      // the control state, because they must read 0 during reset.
      state   <= ST_SAMPLE;
      pp_q    <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      o_end   <= 1'b0;
      o_res   <= '0;
      o_cry   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage read the previous
      // stage's value from before this edge, which is what forms the pipeline.
      case (state)
        ST_SAMPLE: begin
          pp_q  <= pp_d;
          state <= ST_REDUCE;
        end
        ST_REDUCE: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          state   <= ST_FINAL;
        end
        ST_FINAL: begin
          o_res <= prod;
          o_cry <= cry_d;
          o_end <= 1'b1;
          state <= ST_DONE;
        end
        default: state <= ST_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_16bit_wallace_core.sv
// -----------------------------------------------------------------------------
// tb_mul_16bit_wallace_core
// Self-checking bench for mul_16bit_wallace_core. Define
// MUL_16BIT_WALLACE_UNSIGNED_EN for both bench and RTL to check the unsigned
// configuration.
// -----------------------------------------------------------------------------
module tb_mul_16bit_wallace_core;

  logic        clk;
  logic        rst;
  logic [15:0] num_x;
  logic [15:0] num_y;
  logic        res_end;
  logic [31:0] res;
  logic        cry;

  int vectors;
  int miscompares;

  mul_16bit_wallace_core dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_num_x(num_x),
    .i_num_y(num_y),
    .o_end  (res_end),
    .o_res  (res),
    .o_cry  (cry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the arithmetic product and its 16-bit range test.
  function automatic void ref_model(input logic [15:0] x, input logic [15:0] y,
                                    output logic [31:0] p, output logic c);
`ifdef MUL_16BIT_WALLACE_UNSIGNED_EN
    longint prod;
    prod = longint'(x) * longint'(y);
    p    = prod[31:0];
    c    = (prod > 65535);
`else
    longint prod;
    prod = longint'($signed(x)) * longint'($signed(y));
    p    = prod[31:0];
    c    = (prod > 32767) || (prod < -32768);
`endif
  endfunction

  task automatic cmp_outputs(input string name, input logic e_end,
                             input logic [31:0] e_res, input logic e_cry);
    vectors++;
    if (res_end !== e_end || res !== e_res || cry !== e_cry) begin
      miscompares++;
      $display("FAIL %s: got end=%0b res=%08h cry=%0b, need end=%0b res=%08h cry=%0b",
               name, res_end, res, cry, e_end, e_res, e_cry);
    end
  endtask

  // Reset pulse, apply operands, then watch edges 1..3. When scramble is set
  // the inputs are changed right after edge 1 and must not affect the result.
  task automatic run_op(input string name, input logic [15:0] x,
                        input logic [15:0] y, input logic [31:0] e_res,
                        input logic e_cry, input bit scramble);
    @(negedge clk);
    rst   = 1'b1;
    num_x = x;
    num_y = y;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      if (e < 3) cmp_outputs($sformatf("%s edge%0d", name, e), 1'b0, '0, 1'b0);
      else       cmp_outputs($sformatf("%s edge3", name), 1'b1, e_res, e_cry);
      if (e == 1 && scramble) begin
        num_x = 16'($urandom);
        num_y = 16'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst   = 1'b1;
    num_x = 16'h1234;
    num_y = 16'h5678;
    repeat (3) begin
      @(posedge clk);
      #1;
      cmp_outputs("reset_hold", 1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_directed();
`ifdef MUL_16BIT_WALLACE_UNSIGNED_EN
    run_op("u_fffa_fff9", 16'hFFFA, 16'hFFF9, 32'hFFF3_002A, 1'b1, 1'b1);
    run_op("u_00ff_00ff", 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b0, 1'b1);
    run_op("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, 1'b0);
    run_op("u_ffff_0001", 16'hFFFF, 16'h0001, 32'h0000_FFFF, 1'b0, 1'b0);
`else
    run_op("s_m6_m7",     16'hFFFA, 16'hFFF9, 32'h0000_002A, 1'b0, 1'b1);
    run_op("s_m6_5",      16'hFFFA, 16'h0005, 32'hFFFF_FFE2, 1'b0, 1'b1);
    run_op("s_7fff_2",    16'h7FFF, 16'h0002, 32'h0000_FFFE, 1'b1, 1'b0);
    run_op("s_8000_8000", 16'h8000, 16'h8000, 32'h4000_0000, 1'b1, 1'b0);
    run_op("s_0_1234",    16'h0000, 16'h1234, 32'h0000_0000, 1'b0, 1'b0);
    run_op("s_m1_m32768", 16'hFFFF, 16'h8000, 32'h0000_8000, 1'b1, 1'b0);
    run_op("s_m1_32767",  16'hFFFF, 16'h7FFF, 32'hFFFF_8001, 1'b0, 1'b0);
`endif
  endtask

  // Sticky result: o_end/o_res/o_cry hold for 10 cycles while inputs wander.
  task automatic test_hold();
    logic [31:0] e_res;
    logic        e_cry;
    ref_model(16'hFFFA, 16'hFFF9, e_res, e_cry);
    run_op("hold_start", 16'hFFFA, 16'hFFF9, e_res, e_cry, 1'b1);
    repeat (10) begin
      num_x = 16'($urandom);
      num_y = 16'($urandom);
      @(posedge clk);
      #1;
      cmp_outputs("hold", 1'b1, e_res, e_cry);
    end
  endtask

  // Reset after edge 2 clears everything, then the same operation restarts.
  task automatic test_mid_reset();
    logic [15:0] x, y;
    logic [31:0] e_res;
    logic        e_cry;
    x = 16'h7123;
    y = 16'hA5C3;
    ref_model(x, y, e_res, e_cry);
    @(negedge clk);
    rst   = 1'b1;
    num_x = x;
    num_y = y;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    cmp_outputs("midrst_async", 1'b0, '0, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
      cmp_outputs("midrst_held", 1'b0, '0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      if (e < 3) cmp_outputs($sformatf("midrst_restart edge%0d", e), 1'b0, '0, 1'b0);
      else       cmp_outputs("midrst_restart edge3", 1'b1, e_res, e_cry);
    end
    // Reset while done also clears the sticky outputs asynchronously.
    #2;
    rst = 1'b1;
    #1;
    cmp_outputs("done_async_clear", 1'b0, '0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic [31:0] e_res;
    logic        e_cry;
    for (int n = 0; n < 40; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      // Bias a few operands toward the extremes of the range.
      case ($urandom_range(0, 5))
        0: x = 16'h8000;
        1: y = 16'h7FFF;
        2: x = 16'hFFFF;
        default: ;
      endcase
      ref_model(x, y, e_res, e_cry);
      run_op($sformatf("rand%0d_%04h_%04h", n, x, y), x, y, e_res, e_cry, 1'b1);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    num_x = '0;
    num_y = '0;
    test_reset();
    test_directed();
    test_hold();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
